// File: rtl/node_in_queue.sv
// Per-input-port packet queue of a maze node: stores packets with their route request,
// presents the head's outstanding requests to the output arbiters and retires it once all are accepted.
module node_in_queue #(
  parameter int PYLD_W = 32,
  parameter int DEPTH  = 4,
  parameter int NDIR   = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ibuf_vld,
  output logic                         ibuf_rdy,
  input  logic [PYLD_W-1:0]            payload_i,
  input  logic [NDIR-1:0]              route_req,
  output logic [NDIR-1:0]              arb_req,
  input  logic [NDIR-1:0]              arb_gnt,
  input  logic [NDIR-1:0]              obuf_rdy,
  output logic [PYLD_W-1:0]            payload_o,
  output logic [$clog2(DEPTH+1)-1:0]   occ,
  output logic [7:0]                   drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam logic [OW-1:0] FULL_C = OW'(DEPTH);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [PYLD_W-1:0] r_pyld_mem  [DEPTH];
  logic [NDIR-1:0]   r_route_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [OW-1:0]     r_occ;
  logic [NDIR-1:0]   r_served;
  logic [7:0]        r_drop_cnt;

  logic              w_head_vld;
  logic [NDIR-1:0]   w_head_route;
  logic [NDIR-1:0]   w_acc;
  logic              w_push;
  logic              w_done;
  logic              w_unroutable;
  logic              w_pop;

  // Ready looks only at the registered count, so a pop in the same cycle never frees a slot early.
  assign ibuf_rdy     = ~rst & (r_occ < FULL_C);
  assign w_push       = ibuf_vld & ibuf_rdy;

  assign w_head_vld   = (r_occ != '0);
  assign w_head_route = r_route_mem[r_rd_ptr];
  assign payload_o    = r_pyld_mem[r_rd_ptr];

  assign arb_req      = (~rst & w_head_vld) ? (w_head_route & ~r_served) : '0;
  assign w_acc        = arb_gnt & arb_req & obuf_rdy;

  // A multicast head retires only when the accumulated accepts cover every requested output.
  assign w_done       = w_head_vld & (w_head_route != '0) & ((r_served | w_acc) == w_head_route);
  assign w_unroutable = w_head_vld & (w_head_route == '0);
  assign w_pop        = w_done | w_unroutable;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pyld_mem[r_wr_ptr]  <= payload_i;
      r_route_mem[r_wr_ptr] <= route_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_served   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
      r_served <= w_pop ? '0 : (r_served | w_acc);
      if (w_unroutable) r_drop_cnt <= sat_inc8(r_drop_cnt);
    end
  end

  assign occ      = r_occ;
  assign drop_cnt = r_drop_cnt;

endmodule
